alu_cmd_sequencer: RTL and testbench

- Upstream control stage for the 8-bit combinational ALU.
- Accepts commands over a valid/ready handshake and reads operands from a small local register file (or an immediate).
- Drives the ALU's a/b/operation inputs from registers, captures the ALU result, writes it back to a destination register, and returns a response with error and zero status over a second valid/ready handshake.
- Blocks commands the ALU cannot handle cleanly (illegal opcode, divide by zero).

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_cmd_sequencer_if.sv | 37 +++
 rtl/alu_regfile.sv | 24 ++
 rtl/alu_cmd_sequencer.sv | 104 ++++++++++
 tb/tb_alu_cmd_sequencer.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, error codes and FSM states for the ALU command sequencer
package alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SHL  = 4'b0111;
  localparam logic [3:0] OP_SHR  = 4'b1000;
  localparam logic [3:0] OP_LT   = 4'b1001;
  localparam logic [3:0] OP_EQ   = 4'b1010;
  localparam logic [3:0] OP_LOAD = 4'b1111;
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_DIV0    = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;
  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= OP_EQ || op == OP_LOAD;
  endfunction
endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: command, ALU-drive and response signals of the sequencer
interface alu_cmd_sequencer_if #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4
);
  localparam int REG_AW = $clog2(NUM_REGS);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [REG_AW-1:0] cmd_dst;
  logic [REG_AW-1:0] cmd_src_a;
  logic [REG_AW-1:0] cmd_src_b;
  logic              cmd_use_imm;
  logic [DATA_W-1:0] cmd_imm;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [REG_AW-1:0] rsp_dst;
  logic [1:0]        rsp_err;
  logic              rsp_zero;
  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_use_imm, cmd_imm,
    input  alu_result, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_op,
    output rsp_valid, rsp_data, rsp_dst, rsp_err, rsp_zero
  );
  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_use_imm, cmd_imm,
    output alu_result, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_data, rsp_dst, rsp_err, rsp_zero
  );
endinterface

// File: rtl/alu_regfile.sv
// alu_regfile: NUM_REGS x DATA_W registers, two async read ports, one sync write port
module alu_regfile #(
  parameter  int DATA_W   = 8,
  parameter  int NUM_REGS = 4,
  localparam int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr_a,
  input  logic [REG_AW-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  assign o_rdata_a = r_regs[i_raddr_a];
  assign o_rdata_b = r_regs[i_raddr_b];
  // clear on reset, otherwise write the selected register when enabled
  always_ff @(posedge clk)
    if (rst) r_regs <= '{default: '0};
    else if (i_we) r_regs[i_waddr] <= i_wdata;
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: accepts register/immediate commands, drives the ALU, writes back and responds
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int NUM_REGS = 4,
  localparam int REG_AW   = $clog2(NUM_REGS)
) (
  input logic clk,
  input logic rst,
  alu_cmd_sequencer_if.slave bus
);
  state_e            r_state;
  logic [3:0]        r_op;
  logic [REG_AW-1:0] r_dst;
  logic [1:0]        r_err;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [3:0]        r_alu_op;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic [REG_AW-1:0] r_rsp_dst;
  logic [1:0]        r_rsp_err;
  logic              r_rsp_zero;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic [DATA_W-1:0] w_opnd_b;
  logic [1:0]        w_err;
  logic [DATA_W-1:0] w_result;
  logic              w_we;
  alu_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_we),
    .i_waddr   (r_dst),
    .i_wdata   (w_result),
    .i_raddr_a (bus.cmd_src_a),
    .i_raddr_b (bus.cmd_src_b),
    .o_rdata_a (w_rd_a),
    .o_rdata_b (w_rd_b)
  );
  // operand B selection, error classification at accept, and the write-back value in EXEC
  always_comb begin
    w_opnd_b = bus.cmd_use_imm ? bus.cmd_imm : w_rd_b;
    w_err    = !is_legal_op(bus.cmd_op) ? ERR_ILLEGAL :
               (bus.cmd_op == OP_DIV && w_opnd_b == '0) ? ERR_DIV0 : ERR_OK;
    w_result = r_op == OP_LOAD ? r_imm : r_err != ERR_OK ? '0 : bus.alu_result;
    w_we     = r_state == S_EXEC && r_err == ERR_OK;
  end
  // IDLE -> EXEC -> RESP sequencer; ALU inputs and response fields are all registered
  always_ff @(posedge clk)
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_dst       <= '0;
      r_err       <= ERR_OK;
      r_imm       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_dst   <= '0;
      r_rsp_err   <= ERR_OK;
      r_rsp_zero  <= 1'b0;
    end else
      case (r_state)
        S_IDLE:
          if (bus.cmd_valid) begin
            r_alu_a  <= w_rd_a;
            r_alu_b  <= w_opnd_b;
            r_alu_op <= (w_err != ERR_OK || bus.cmd_op == OP_LOAD) ? OP_ADD : bus.cmd_op;
            r_op     <= bus.cmd_op;
            r_dst    <= bus.cmd_dst;
            r_err    <= w_err;
            r_imm    <= bus.cmd_imm;
            r_state  <= S_EXEC;
          end
        S_EXEC: begin
          r_rsp_data  <= w_result;
          r_rsp_dst   <= r_dst;
          r_rsp_err   <= r_err;
          r_rsp_zero  <= w_result == '0 && r_err == ERR_OK;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP:
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        default: r_state <= S_IDLE;
      endcase
  assign bus.cmd_ready = r_state == S_IDLE && !rst;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_op    = r_alu_op;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_dst   = r_rsp_dst;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_zero  = r_rsp_zero;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed bench with a reference ALU driving alu_result
module tb_alu_cmd_sequencer;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_errors = 0;
  alu_cmd_sequencer_if bus ();
  alu_cmd_sequencer dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  // reference 8-bit combinational ALU
  always_comb
    case (bus.alu_op)
      OP_ADD:  bus.alu_result = bus.alu_a + bus.alu_b;
      OP_SUB:  bus.alu_result = bus.alu_a - bus.alu_b;
      OP_MUL:  bus.alu_result = bus.alu_a * bus.alu_b;
      OP_DIV:  bus.alu_result = bus.alu_b == 8'd0 ? 8'd0 : bus.alu_a / bus.alu_b;
      OP_AND:  bus.alu_result = bus.alu_a & bus.alu_b;
      OP_OR:   bus.alu_result = bus.alu_a | bus.alu_b;
      OP_XOR:  bus.alu_result = bus.alu_a ^ bus.alu_b;
      OP_SHL:  bus.alu_result = bus.alu_a << bus.alu_b[2:0];
      OP_SHR:  bus.alu_result = bus.alu_a >> bus.alu_b[2:0];
      OP_LT:   bus.alu_result = {7'd0, bus.alu_a < bus.alu_b};
      OP_EQ:   bus.alu_result = {7'd0, bus.alu_a == bus.alu_b};
      default: bus.alu_result = 8'd0;
    endcase
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic set_cmd(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                         input logic [1:0] sb, input logic ui, input logic [7:0] imm);
    bus.cmd_op = op;
    bus.cmd_dst = dst;
    bus.cmd_src_a = sa;
    bus.cmd_src_b = sb;
    bus.cmd_use_imm = ui;
    bus.cmd_imm = imm;
    bus.cmd_valid = 1'b1;
  endtask
  task automatic issue(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                       input logic [1:0] sb, input logic ui, input logic [7:0] imm);
    int n = 0;
    @(negedge clk);
    set_cmd(op, dst, sa, sb, ui, imm);
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("accept_timeout", 32'(bus.cmd_ready), 32'(1));
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask
  task automatic run_cmd(input string tag, input logic [3:0] op, input logic [1:0] dst,
                         input logic [1:0] sa, input logic [1:0] sb, input logic ui,
                         input logic [7:0] imm, input logic [7:0] ea, input logic [7:0] eb,
                         input logic [3:0] eop, input logic [7:0] ed, input logic [1:0] ee,
                         input logic ez);
    issue(op, dst, sa, sb, ui, imm);
    @(negedge clk);
    chk({tag, "_alu_a"}, 32'(bus.alu_a), 32'(ea));
    chk({tag, "_alu_b"}, 32'(bus.alu_b), 32'(eb));
    chk({tag, "_alu_op"}, 32'(bus.alu_op), 32'(eop));
    chk({tag, "_exec_valid"}, 32'(bus.rsp_valid), 32'(0));
    @(negedge clk);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(1));
    chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'(ed));
    chk({tag, "_rsp_dst"}, 32'(bus.rsp_dst), 32'(dst));
    chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'(ee));
    chk({tag, "_rsp_zero"}, 32'(bus.rsp_zero), 32'(ez));
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 4'd0;
    bus.cmd_dst = 2'd0;
    bus.cmd_src_a = 2'd0;
    bus.cmd_src_b = 2'd0;
    bus.cmd_use_imm = 1'b0;
    bus.cmd_imm = 8'd0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'(0));
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    chk("rst_alu_a", 32'(bus.alu_a), 32'(0));
    chk("rst_alu_op", 32'(bus.alu_op), 32'(0));
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'(1));
    run_cmd("load_r0", OP_LOAD, 2'd0, 2'd0, 2'd0, 1'b1, 8'd3, 8'd0, 8'd3, OP_ADD, 8'd3, ERR_OK, 1'b0);
    run_cmd("load_r1", OP_LOAD, 2'd1, 2'd0, 2'd0, 1'b1, 8'd5, 8'd3, 8'd5, OP_ADD, 8'd5, ERR_OK, 1'b0);
    run_cmd("add_r2", OP_ADD, 2'd2, 2'd0, 2'd1, 1'b0, 8'd0, 8'd3, 8'd5, OP_ADD, 8'd8, ERR_OK, 1'b0);
    run_cmd("sub_r3", OP_SUB, 2'd3, 2'd0, 2'd1, 1'b0, 8'd0, 8'd3, 8'd5, OP_SUB, 8'hFE, ERR_OK, 1'b0);
    run_cmd("load_r3", OP_LOAD, 2'd3, 2'd0, 2'd0, 1'b1, 8'h20, 8'd3, 8'h20, OP_ADD, 8'h20, ERR_OK, 1'b0);
    run_cmd("mul_wrap", OP_MUL, 2'd2, 2'd3, 2'd0, 1'b1, 8'h10, 8'h20, 8'h10, OP_MUL, 8'h00, ERR_OK, 1'b1);
    run_cmd("div0", OP_DIV, 2'd1, 2'd0, 2'd0, 1'b1, 8'd0, 8'd3, 8'd0, OP_ADD, 8'd0, ERR_DIV0, 1'b0);
    run_cmd("rd_r1", OP_ADD, 2'd1, 2'd1, 2'd0, 1'b1, 8'd0, 8'd5, 8'd0, OP_ADD, 8'd5, ERR_OK, 1'b0);
    run_cmd("illegal", 4'b1011, 2'd0, 2'd1, 2'd0, 1'b1, 8'd9, 8'd5, 8'd9, OP_ADD, 8'd0, ERR_ILLEGAL, 1'b0);
    run_cmd("rd_r0", OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 8'd0, 8'd3, 8'd0, OP_ADD, 8'd3, ERR_OK, 1'b0);
    run_cmd("load_r2", OP_LOAD, 2'd2, 2'd0, 2'd0, 1'b1, 8'd7, 8'd3, 8'd7, OP_ADD, 8'd7, ERR_OK, 1'b0);
    run_cmd("load_r3b", OP_LOAD, 2'd3, 2'd0, 2'd0, 1'b1, 8'd7, 8'd3, 8'd7, OP_ADD, 8'd7, ERR_OK, 1'b0);
    run_cmd("eq", OP_EQ, 2'd0, 2'd2, 2'd3, 1'b0, 8'd0, 8'd7, 8'd7, OP_EQ, 8'd1, ERR_OK, 1'b0);
    bus.rsp_ready = 1'b0;
    issue(OP_ADD, 2'd1, 2'd1, 2'd0, 1'b1, 8'd2);
    @(negedge clk);
    @(negedge clk);
    chk("bp_valid", 32'(bus.rsp_valid), 32'(1));
    set_cmd(OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 8'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 32'(bus.rsp_valid), 32'(1));
      chk("bp_hold_data", 32'(bus.rsp_data), 32'(7));
      chk("bp_hold_dst", 32'(bus.rsp_dst), 32'(1));
      chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'(0));
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_valid", 32'(bus.rsp_valid), 32'(0));
    chk("bp_idle_ready", 32'(bus.cmd_ready), 32'(1));
    chk("bp_idle_alu_a", 32'(bus.alu_a), 32'(5));
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("bp_next_alu_a", 32'(bus.alu_a), 32'(7));
    chk("bp_next_alu_b", 32'(bus.alu_b), 32'(1));
    chk("bp_next_cmd_ready", 32'(bus.cmd_ready), 32'(0));
    @(negedge clk);
    chk("bp_next_valid", 32'(bus.rsp_valid), 32'(1));
    chk("bp_next_data", 32'(bus.rsp_data), 32'(8));
    @(posedge clk);
    #1;
    issue(OP_ADD, 2'd2, 2'd0, 2'd1, 1'b0, 8'd0);
    rst = 1'b1;
    #1 chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'(1));
    chk("midrst_alu_a", 32'(bus.alu_a), 32'(0));
    chk("midrst_alu_b", 32'(bus.alu_b), 32'(0));
    @(negedge clk);
    chk("midrst_rsp_valid2", 32'(bus.rsp_valid), 32'(0));
    run_cmd("clr_r01", OP_ADD, 2'd0, 2'd0, 2'd1, 1'b0, 8'd0, 8'd0, 8'd0, OP_ADD, 8'd0, ERR_OK, 1'b1);
    run_cmd("clr_r23", OP_ADD, 2'd3, 2'd2, 2'd3, 1'b0, 8'd0, 8'd0, 8'd0, OP_ADD, 8'd0, ERR_OK, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
